// File: rtl/gf_mul_inv_seq.sv
// rtl/gf_mul_inv_seq.sv - sequential GF(2^M) multiplier / inverter with programmable polynomial
//
// Computes a*b (mode=0) or a^(2^M-2) (mode=1) modulo x^M + poly using one
// shared MSB-first bit-serial multiplier (one operand bit per cycle).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  request handshake; a, b, poly, mode sampled on accept
//   mode                 0 = multiply, 1 = inverse (b ignored)
//   a, b, poly           operands and low M polynomial coefficients (x^M implicit)
//   out_valid/out_ready  result handshake; result and err held until accepted
//   result, err          product/inverse; err flags an inverse of zero
//   busy                 high whenever the unit is not idle
module gf_mul_inv_seq #(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] poly,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] result,
  output logic         err,
  output logic         busy
);

  localparam int CW = $clog2(M) + 1;
  localparam logic [CW-1:0] LAST = CW'(M - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    INV_SQR = 3'd2,
    INV_MUL = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [M-1:0]   x_q, x_d;        // multiplicand, added when the current y bit is set
  logic [M-1:0]   y_q, y_d;        // multiplier, shifted left so bit M-1 is the current bit
  logic [M-1:0]   acc_q, acc_d;
  logic [M-1:0]   poly_q, poly_d;
  logic [M-1:0]   s_q, s_d;        // running square a^(2^k)
  logic [M-1:0]   r_q, r_d;        // running product of the squares
  logic [CW-1:0]  cnt_q, cnt_d;    // bit index within one multiply
  logic [CW-1:0]  iter_q, iter_d;  // inverse iteration k
  logic           zero_q, zero_d;  // inverse requested with a == 0
  logic [M-1:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [M-1:0]   step_acc;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign err       = err_q;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    poly_d   = poly_q;
    s_d      = s_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    zero_d   = zero_q;
    result_d = result_q;
    err_d    = err_q;

    // acc = xtime(acc) ^ (y[j] ? x : 0)
    step_acc = {acc_q[M-2:0], 1'b0}
             ^ ({M{acc_q[M-1]}} & poly_q)
             ^ ({M{y_q[M-1]}} & x_q);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          poly_d = poly;
          acc_d  = '0;
          cnt_d  = '0;
          if (mode) begin
            s_d     = a;
            r_d     = M'(1);
            x_d     = a;
            y_d     = a;
            iter_d  = CW'(1);
            zero_d  = (a == '0);
            state_d = INV_SQR;
          end else begin
            x_d     = a;
            y_d     = b;
            state_d = MUL;
          end
        end
      end

      MUL: begin
        acc_d = step_acc;
        y_d   = y_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          result_d = step_acc;
          err_d    = 1'b0;
          state_d  = DONE;
        end
      end

      INV_SQR: begin
        if (zero_q) begin
          // Zero has no inverse: report after a single cycle.
          result_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end else begin
          acc_d = step_acc;
          y_d   = y_q << 1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            s_d     = step_acc;
            x_d     = r_q;
            y_d     = step_acc;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = INV_MUL;
          end
        end
      end

      INV_MUL: begin
        acc_d = step_acc;
        y_d   = y_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          r_d = step_acc;
          if (iter_q == LAST) begin
            result_d = step_acc;
            err_d    = 1'b0;
            state_d  = DONE;
          end else begin
            iter_d  = iter_q + CW'(1);
            x_d     = s_q;
            y_d     = s_q;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = INV_SQR;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      poly_q   <= '0;
      s_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      iter_q   <= '0;
      zero_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      poly_q   <= poly_d;
      s_q      <= s_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      iter_q   <= iter_d;
      zero_q   <= zero_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_gf_mul_inv_seq.sv
// tb/tb_gf_mul_inv_seq.sv - self-checking bench for gf_mul_inv_seq (M=8 and M=4 instances)
module tb_gf_mul_inv_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv8, ir8, md8, ov8, or8, err8, bz8;
  logic [7:0] a8, b8, p8, res8;
  logic       iv4, ir4, md4, ov4, or4, err4, bz4;
  logic [3:0] a4, b4, p4, res4;

  gf_mul_inv_seq #(.M(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .mode(md8),
    .a(a8), .b(b8), .poly(p8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .err(err8), .busy(bz8)
  );

  gf_mul_inv_seq #(.M(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .mode(md4),
    .a(a4), .b(b4), .poly(p4), .out_valid(ov4), .out_ready(or4),
    .result(res4), .err(err4), .busy(bz4)
  );

  int n_chk  = 0;
  int n_fail = 0;

  int          cur = 8;
  bit          exp_active = 1'b0;
  logic [15:0] exp_res = '0;
  logic        exp_err = 1'b0;
  logic [15:0] r;
  logic        e;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: carry-less long multiplication, then long division by x^m + p.
  function automatic logic [15:0] m_mul(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] p, input int m);
    logic [31:0] prod, modp, xm, ym;
    logic [15:0] mask;
    mask = 16'((32'd1 << m) - 32'd1);
    xm   = {16'd0, x & mask};
    ym   = {16'd0, y & mask};
    modp = (32'd1 << m) | {16'd0, p & mask};
    prod = '0;
    for (int i = 0; i < m; i++) if (ym[i]) prod = prod ^ (xm << i);
    for (int i = 2 * m - 2; i >= m; i--) if (prod[i]) prod = prod ^ (modp << (i - m));
    return prod[15:0];
  endfunction

  // a^(2^m - 2) by repeated multiplication.
  function automatic logic [15:0] m_inv(input logic [15:0] x, input logic [15:0] p, input int m);
    logic [15:0] acc;
    acc = 16'd1;
    for (int i = 0; i < (1 << m) - 2; i++) acc = m_mul(acc, x, p, m);
    return acc;
  endfunction

  function automatic logic get_ov(input int s);
    return (s == 4) ? ov4 : ov8;
  endfunction
  function automatic logic get_ir(input int s);
    return (s == 4) ? ir4 : ir8;
  endfunction
  function automatic logic [15:0] get_res(input int s);
    return (s == 4) ? {12'd0, res4} : {8'd0, res8};
  endfunction
  function automatic logic get_err(input int s);
    return (s == 4) ? err4 : err8;
  endfunction

  task automatic drive(input int s, input logic v, input logic md,
                       input logic [15:0] av, input logic [15:0] bv, input logic [15:0] pv);
    if (s == 4) begin
      iv4 = v; md4 = md; a4 = av[3:0]; b4 = bv[3:0]; p4 = pv[3:0];
    end else begin
      iv8 = v; md8 = md; a8 = av[7:0]; b8 = bv[7:0]; p8 = pv[7:0];
    end
  endtask

  task automatic set_ready(input int s, input logic v);
    if (s == 4) or4 = v; else or8 = v;
  endtask

  // Every cycle: while a result is presented it must match the model, and
  // busy/in_ready/out_valid must be consistent with the state they encode.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov8) begin
        chk("ov8_expected", {31'd0, exp_active && cur == 8}, 32'd1);
        if (exp_active && cur == 8) begin
          chk("res8", {16'd0, res8 & 8'hFF}, {16'd0, exp_res});
          chk("err8", {31'd0, err8}, {31'd0, exp_err});
        end
        chk("ir8_low_in_done", {31'd0, ir8}, 32'd0);
      end
      chk("busy8_vs_ready", {31'd0, bz8}, {31'd0, !ir8});
      if (ov4) begin
        chk("ov4_expected", {31'd0, exp_active && cur == 4}, 32'd1);
        if (exp_active && cur == 4) begin
          chk("res4", {28'd0, res4}, {16'd0, exp_res});
          chk("err4", {31'd0, err4}, {31'd0, exp_err});
        end
        chk("ir4_low_in_done", {31'd0, ir4}, 32'd0);
      end
      chk("busy4_vs_ready", {31'd0, bz4}, {31'd0, !ir4});
    end
  end

  task automatic run_op(input int s, input logic md, input logic [15:0] av,
                        input logic [15:0] bv, input logic [15:0] pv, input int hold,
                        input bit inject, input bit use_lit, input logic [15:0] lit,
                        output logic [15:0] ro, output logic eo);
    int w;
    int cyc;
    int exp_lat;
    logic [15:0] mask;
    mask = 16'((32'd1 << s) - 32'd1);
    ro = '0;
    eo = 1'b0;
    w = 0;
    while (!get_ir(s) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'd0, get_ir(s)}, 32'd1);
    cur = s;
    exp_res = md ? m_inv(av, pv, s) : m_mul(av, bv, pv, s);
    exp_err = md && ((av & mask) == 16'd0);
    exp_lat = !md ? s : (((av & mask) == 16'd0) ? 1 : 2 * (s - 1) * s);
    exp_active = 1'b1;
    drive(s, 1'b1, md, av, bv, pv);
    @(posedge clk);
    #1;
    // Operands change right after the accept edge; the result must not care.
    drive(s, 1'b0, $urandom_range(0, 1), 16'($urandom), 16'($urandom), 16'($urandom));
    @(negedge clk);
    cyc = 0;
    while (!get_ov(s) && cyc < 400) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("latency", cyc, exp_lat);
    ro = get_res(s);
    eo = get_err(s);
    if (use_lit) chk("literal_result", {16'd0, ro}, {16'd0, lit});
    for (int i = 0; i < hold; i++) begin
      if (inject && i == 0) drive(s, 1'b1, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom));
      @(negedge clk);
    end
    set_ready(s, 1'b1);
    @(posedge clk);
    #1;
    set_ready(s, 1'b0);
    drive(s, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0);
    exp_active = 1'b0;
    @(negedge clk);
    chk("ov_drop_after_handshake", {31'd0, get_ov(s)}, 32'd0);
    chk("ready_after_handshake", {31'd0, get_ir(s)}, 32'd1);
    if (inject) begin
      @(negedge clk);
      chk("injected_req_ignored", {31'd0, get_ir(s)}, 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    iv8 = 0; md8 = 0; a8 = 0; b8 = 0; p8 = 0; or8 = 0;
    iv4 = 0; md4 = 0; a4 = 0; b4 = 0; p4 = 0; or4 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ir8", {31'd0, ir8}, 32'd1);
    chk("rst_ov8", {31'd0, ov8}, 32'd0);
    chk("rst_res8", {24'd0, res8}, 32'd0);
    chk("rst_err8", {31'd0, err8}, 32'd0);
    chk("rst_busy8", {31'd0, bz8}, 32'd0);
    chk("rst_ir4", {31'd0, ir4}, 32'd1);
    chk("rst_ov4", {31'd0, ov4}, 32'd0);
    chk("rst_res4", {28'd0, res4}, 32'd0);

    // Hand-computed values that pin the reference model.
    chk("model_mul_57_83", {16'd0, m_mul(16'h57, 16'h83, 16'h1B, 8)}, 32'hC1);
    chk("model_inv_53", {16'd0, m_inv(16'h53, 16'h1B, 8)}, 32'hCA);
    chk("model_m4_inv_2", {16'd0, m_inv(16'h2, 16'h3, 4)}, 32'h9);
    chk("model_m4_mul_9_2", {16'd0, m_mul(16'h9, 16'h2, 16'h3, 4)}, 32'h1);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // M=8 directed.
    run_op(8, 0, 16'h57, 16'h83, 16'h1B, 0, 0, 1, 16'hC1, r, e);
    run_op(8, 0, 16'h02, 16'h80, 16'h1B, 1, 0, 1, 16'h1B, r, e);
    run_op(8, 1, 16'h53, 16'h00, 16'h1B, 0, 0, 1, 16'hCA, r, e);
    run_op(8, 1, 16'h01, 16'h00, 16'h1B, 0, 0, 1, 16'h01, r, e);
    run_op(8, 1, 16'h00, 16'h00, 16'h1B, 2, 0, 1, 16'h00, r, e);
    chk("inv_zero_err", {31'd0, e}, 32'd1);
    // Back-to-back with a resampled polynomial.
    run_op(8, 0, 16'h02, 16'h80, 16'h1D, 0, 0, 1, 16'h1D, r, e);
    run_op(8, 0, 16'h02, 16'h80, 16'h1B, 0, 0, 1, 16'h1B, r, e);
    // Backpressure with an ignored request.
    run_op(8, 0, 16'h57, 16'h83, 16'h1B, 20, 1, 1, 16'hC1, r, e);

    // Reset in the middle of an inverse.
    cur = 8;
    exp_res = m_inv(16'h53, 16'h1B, 8);
    exp_err = 1'b0;
    exp_active = 1'b1;
    drive(8, 1'b1, 1'b1, 16'h53, 16'h00, 16'h1B);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 1'b0, 16'h00, 16'h00, 16'h00);
    repeat (50) @(posedge clk);
    #2;
    exp_active = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ov", {31'd0, ov8}, 32'd0);
    chk("midrst_res", {24'd0, res8}, 32'd0);
    chk("midrst_busy", {31'd0, bz8}, 32'd0);
    chk("midrst_ready", {31'd0, ir8}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8, 0, 16'h57, 16'h83, 16'h1B, 0, 0, 1, 16'hC1, r, e);

    // M=8 random.
    for (int n = 0; n < 25; n++) begin
      run_op(8, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)),
             16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
             $urandom_range(0, 3), 0, 0, 16'd0, r, e);
    end

    // M=4 directed and exhaustive x * inv(x) = 1.
    run_op(4, 1, 16'h2, 16'h0, 16'h3, 0, 0, 1, 16'h9, r, e);
    run_op(4, 0, 16'h9, 16'h2, 16'h3, 0, 0, 1, 16'h1, r, e);
    for (int x = 1; x < 16; x++) begin
      logic [15:0] inv;
      run_op(4, 1, 16'(x), 16'h0, 16'h3, 0, 0, 0, 16'd0, inv, e);
      run_op(4, 0, 16'(x), inv, 16'h3, 0, 0, 0, 16'd0, r, e);
      chk("m4_x_times_inv", {16'd0, r}, 32'd1);
    end

    // M=4 random, any polynomial.
    for (int n = 0; n < 20; n++) begin
      run_op(4, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)),
             16'($urandom_range(0, 15)), 16'($urandom_range(0, 15)),
             $urandom_range(0, 3), 0, 0, 16'd0, r, e);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
